// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bus bundle for mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] mem_readAddr;
    logic [13:0] mem_writeAddr;
    logic        mem_readEn;
    logic        mem_writeEn;
    logic [31:0] mem_dIn;
    logic [31:0] mem_dOut;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_dOut,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_readAddr, mem_writeAddr, mem_readEn, mem_writeEn, mem_dIn
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_dOut,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_readAddr, mem_writeAddr, mem_readEn, mem_writeEn, mem_dIn
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit with read-modify-write for sub-word stores
module mem_access_unit (
    input  logic             clk,
    input  logic             reset_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_write, r_signed, r_err;
    logic [1:0]  r_size;
    logic [15:0] r_addr;
    logic [31:0] r_din, r_rdata;
    logic        w_accept, w_err;
    logic        w_req_ready, w_resp_valid, w_read_en, w_write_en;
    logic [31:0] w_lane, w_load, w_merge;

    assign w_accept = bus.req_valid & w_req_ready;
    assign w_err    = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_read_en    = 1'b0;
        w_write_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err)                          w_next = S_RESP;
                    else if (bus.req_write && bus.req_size == 2'b10) w_next = S_WR;
                    else                                w_next = S_RD;
                end
            end
            S_RD: begin
                w_read_en = 1'b1;
                w_next    = S_RWAIT;
            end
            S_RWAIT: w_next = r_write ? S_WR : S_RESP;
            S_WR: begin
                w_write_en = 1'b1;
                w_next     = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_din holds the right-aligned store data until the old word arrives, then the merged word
    always_comb begin
        w_lane  = bus.mem_dOut >> {r_addr[1:0], 3'b000};
        w_merge = bus.mem_dOut;
        case (r_size)
            2'b00: begin
                w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_din[7:0];
            end
            2'b01: begin
                w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_din[15:0];
            end
            default: begin
                w_load  = bus.mem_dOut;
                w_merge = r_din;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= 16'h0000;
            r_err    <= 1'b0;
            r_din    <= 32'h0;
            r_rdata  <= 32'h0;
        end else if (w_accept) begin
            r_write  <= bus.req_write;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_addr   <= bus.req_addr;
            r_err    <= w_err;
            r_din    <= bus.req_wdata;
            r_rdata  <= 32'h0;
        end else if (r_state == S_RWAIT) begin
            if (r_write) r_din   <= w_merge;
            else         r_rdata <= w_load;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.resp_valid    = w_resp_valid;
    assign bus.resp_rdata    = r_rdata;
    assign bus.resp_err      = r_err;
    assign bus.mem_readEn    = w_read_en;
    assign bus.mem_writeEn   = w_write_en;
    assign bus.mem_readAddr  = r_addr[15:2];
    assign bus.mem_writeAddr = r_addr[15:2];
    assign bus.mem_dIn       = r_din;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit dut (.clk(clk), .reset_n(rst_n), .bus(bus));

    logic [31:0] env_mem [0:16383];
    logic [31:0] ref_mem [int];
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    int tests = 0;
    int fails = 0;
    int en_count = 0;
    int conflict = 0;
    logic [13:0] last_waddr = '0;
    logic [31:0] last_din = '0;

    always @(posedge clk) begin
        if (bd_we) env_mem[bd_addr] <= bd_data;
        else if (bus.mem_writeEn) env_mem[bus.mem_writeAddr] <= bus.mem_dIn;
        if (bus.mem_readEn) bus.mem_dOut <= env_mem[bus.mem_readAddr];
    end

    always @(negedge clk) begin
        if (bus.mem_readEn || bus.mem_writeEn) en_count++;
        if (bus.mem_readEn && bus.mem_writeEn) conflict++;
        if (bus.mem_writeEn) begin
            last_waddr = bus.mem_writeAddr;
            last_din   = bus.mem_dIn;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [15:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.resp_rdata;
        e  = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.resp_valid, 1);
            check("hold_rdata", bus.resp_rdata, rd);
            check("hold_err", bus.resp_err, e);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("idle_req_ready", bus.req_ready, 1);
        check("idle_resp_valid", bus.resp_valid, 0);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input int nb, input logic sg);
        longint v;
        v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * nb));
        if (sg && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd, input int off, input int nb);
        longint mask, v;
        mask = ((longint'(1) << (8 * nb)) - 1) << (8 * off);
        v = (longint'(old) & ~mask) | ((longint'(wd) << (8 * off)) & mask);
        return v[31:0];
    endfunction

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [15:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [31:0] din;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, e0, nb, off, idx, hold, exp_lat;
        logic        w, sg, exp_err;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] wd, exp_rd;

        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;

        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = 14'(k);
            bd_data = (k >= 64) ? $urandom : 32'h0;
            ref_mem[k] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_read_en", bus.mem_readEn, 0);
        check("rst_write_en", bus.mem_writeEn, 0);
        rst_n = 1'b1;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'h0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344, 32'h0,        1'b0, 2, 32'h11223344};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 16'h0012, 32'h000000AA, 32'h0,        1'b0, 4, 32'h11AA3344};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'h11AA3344, 1'b0, 3, 32'h0};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'h80FF7F01, 32'h0,        1'b0, 2, 32'h80FF7F01};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 16'h0012, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 32'h0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 16'h0011, 32'h0,        32'h0000007F, 1'b0, 3, 32'h0};
        tbl[8]  = '{1'b0, 2'd1, 1'b1, 16'h0012, 32'h0,        32'hFFFF80FF, 1'b0, 3, 32'h0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 16'h0013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 32'h0};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 16'h0010, 32'h0,        32'h00007F01, 1'b0, 3, 32'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 16'h0013, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 16'h0010, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 16'h0011, 32'h12345678, 32'h0,        1'b1, 1, 32'h0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 16'h0012, 32'hCAFE1234, 32'h0,        1'b0, 4, 32'h12347F01};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'h12347F01, 1'b0, 3, 32'h0};

        for (int i = 0; i < 16; i++) begin
            e0 = en_count;
            run(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, 0, rd, e, lat);
            check($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("v%0d_err", i), e, tbl[i].err);
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            if (tbl[i].err) check($sformatf("v%0d_no_mem_enable", i), en_count - e0, 0);
            else if (tbl[i].w) begin
                check($sformatf("v%0d_mem_dIn", i), last_din, tbl[i].din);
                check($sformatf("v%0d_mem_writeAddr", i), last_waddr, tbl[i].a[15:2]);
            end
        end

        run(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 5, rd, e, lat);
        check("stall_rdata", rd, 32'h12347F01);
        check("stall_latency", lat, 3);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 16'h0020; bus.req_wdata = 32'h55555555;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_write_active", bus.mem_writeEn, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_write_en", bus.mem_writeEn, 0);
        check("abort_read_en", bus.mem_readEn, 0);
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_resp_rdata", bus.resp_rdata, 0);
        check("abort_resp_err", bus.resp_err, 0);
        check("abort_write_addr", bus.mem_writeAddr, 0);
        check("abort_read_addr", bus.mem_readAddr, 0);
        check("abort_mem_dIn", bus.mem_dIn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_response", bus.resp_valid, 0);
        end
        check("abort_mem_unchanged", env_mem[8], 32'h0);

        for (int it = 0; it < 200; it++) begin
            a    = 16'h0100 + 16'($urandom_range(0, 63));
            sz   = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            off  = a % 4;
            idx  = a / 4;
            exp_err = (sz == 3) || (a % nb != 0);
            exp_rd  = 32'h0;
            if (exp_err)   exp_lat = 1;
            else if (!w)   exp_lat = 3;
            else if (nb == 4) exp_lat = 2;
            else           exp_lat = 4;
            if (!exp_err && !w) exp_rd = model_load(ref_mem[idx], off, nb, sg);
            if (!exp_err && w)  ref_mem[idx] = model_store(ref_mem[idx], wd, off, nb);
            run(w, sz, sg, a, wd, hold, rd, e, lat);
            check($sformatf("rnd%0d_rdata", it), rd, exp_rd);
            check($sformatf("rnd%0d_err", it), e, exp_err);
            check($sformatf("rnd%0d_latency", it), lat, exp_lat);
        end
        for (int k = 64; k < 80; k++) check($sformatf("mem_word%0d", k), env_mem[k], ref_mem[k]);
        check("en_conflict", conflict, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  unit idle, can accept a request; high exactly when state==IDLE.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-009 req_addr  input  16  byte address; word address = req_addr[15:2].
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  response valid; held until accepted.
REQ-012 resp_ready  input  1  requester accepts response.
REQ-013 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request.
REQ-015 mem_readAddr  output  14  word address to data memory read port.
REQ-016 mem_writeAddr  output  14  word address to data memory write port.
REQ-017 mem_readEn  output  1  memory read enable.
REQ-018 mem_writeEn  output  1  memory write enable; memory writes mem_dIn on rising edge while high.
REQ-019 mem_dIn  output  32  write data to memory.
REQ-020 mem_dOut  input  32  memory read data; valid in the cycle after the cycle mem_readEn was high.

Function
REQ-021 States: IDLE, RD, RWAIT, WR, RESP; request accepted on rising edge with req_valid & req_ready; request fields registered at acceptance.
REQ-022 Acceptance transitions: error -> RESP; load -> RD; word store -> WR; byte/half store -> RD (read-modify-write).
REQ-023 Error: req_size==11, half with addr[0]=1, or word with addr[1:0]!=0; no memory enable asserted; resp_err=1, resp_rdata=0.
REQ-024 RD: mem_readEn=1 and mem_readAddr=addr[15:2] for exactly one cycle; then RWAIT.
REQ-025 RWAIT: mem_readEn=0; mem_dOut captured at the rising edge ending RWAIT; load -> RESP, sub-word store -> WR.
REQ-026 WR: mem_writeEn=1, mem_writeAddr=addr[15:2] for exactly one cycle; then RESP.
REQ-027 Byte lanes little-endian: byte k=addr[1:0] occupies bits [8k+7:8k]; halfword h=addr[1] occupies bits [16h+15:16h].
REQ-028 Sub-word store: mem_dIn = captured word with only the addressed lane replaced by req_wdata low bits; other lanes unchanged. Word store: mem_dIn=req_wdata.
REQ-029 Load result: addressed lane shifted to bit 0, bits above extended per req_signed; word loads unmodified.
REQ-030 RESP: resp_valid=1 with stable resp_rdata/resp_err until the edge where resp_ready=1, then IDLE; no new request accepted in the same edge.
REQ-031 Latency acceptance->resp_valid: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-032 mem_readEn and mem_writeEn SHALL never be high in the same cycle; both low outside RD/WR.

Reset
REQ-033 reset_n low SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_readEn=0, mem_writeEn=0, mem addresses=0, mem_dIn=0.
REQ-034 Reset during WR aborts the write (mem_writeEn drops asynchronously); reset during any other state discards the request with no response.

Verification
REQ-035 Word store addr 0x0010 data 0xDEADBEEF, then word load addr 0x0010 -> mem_writeAddr=4, response 0xDEADBEEF, err=0, latencies 2 and 3.
REQ-036 Memory word 4 = 0x11223344; byte store 0xAA to 0x0012 -> mem_dIn=0x11AA3344; subsequent word load returns 0x11AA3344.
REQ-037 Memory word 4 = 0x80FF7F01; signed byte load 0x0012 -> 0xFFFFFFFF; unsigned byte 0x0011 -> 0x0000007F; signed half 0x0012 -> 0xFFFF80FF.
REQ-038 Word load 0x0013 and req_size=11 -> resp_err=1, resp_rdata=0, mem_readEn/mem_writeEn never asserted, latency 1.
REQ-039 resp_ready held low 5 cycles in RESP -> resp_valid and data stable, req_ready=0 throughout; released -> IDLE next edge.
REQ-040 reset_n pulsed low during WR of a store -> all outputs at reset values immediately, memory word unchanged, no response.
